fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter BOOT_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port icache_req_o, output, 1 bit: one-cycle fetch request pulse.
REQ-005 SHALL have port icache_addr_o, output, 32 bits: byte address of the request, bits [1:0] always 0.
REQ-006 SHALL have port icache_rvalid_i, input, 1 bit: response valid; one response per request, at least 1 cycle after the request.
REQ-007 SHALL have port icache_rdata_i, input, 32 bits: instruction word, sampled when icache_rvalid_i=1.
REQ-008 SHALL have port redirect_i, input, 1 bit: branch/jump taken; flush and refetch.
REQ-009 SHALL have port redirect_pc_i, input, 32 bits: target byte address.
REQ-010 SHALL have port dec_ready_i, input, 1 bit: decode accepts the head instruction this cycle.
REQ-011 SHALL have port inst_valid_o, output, 1 bit: head instruction valid.
REQ-012 SHALL have port inst_o, output, 32 bits: head instruction word.
REQ-013 SHALL have port pc_o, output, 32 bits: byte address of the head instruction.

Function
REQ-014 SHALL hold fetch_pc (32 b), a 2-entry FIFO of {pc, inst}, a FIFO count (0..2) and an FSM with states FETCH, WAIT and KILL.
REQ-015 In FETCH, SHALL issue a request when count + 0 < 2: icache_req_o=1, icache_addr_o=fetch_pc, fetch_pc <= fetch_pc+4 (modulo 2^32, wraps 32'hFFFF_FFFC -> 0), next state WAIT.
REQ-016 SHALL allow at most one outstanding request and SHALL hold icache_req_o=0 in WAIT and KILL.
REQ-017 SHALL drive icache_addr_o = fetch_pc whenever icache_req_o=0.
REQ-018 In WAIT, SHALL push {issued pc, icache_rdata_i} into the FIFO when icache_rvalid_i=1, then go to FETCH; the next request comes no earlier than the following cycle.
REQ-019 In FETCH, SHALL ignore icache_rvalid_i.
REQ-020 SHALL drive inst_valid_o = (count != 0), with inst_o and pc_o taken from the FIFO head; when the FIFO is empty, inst_o and pc_o SHALL be 0.
REQ-021 SHALL pop the head when inst_valid_o and dec_ready_i are both 1.
REQ-022 On a same-cycle push and pop, count SHALL be unchanged and order SHALL be preserved.
REQ-023 Head fields SHALL stay stable while inst_valid_o=1 and dec_ready_i=0.
REQ-024 Redirect SHALL have the highest priority; on redirect_i=1:
  - FIFO emptied (count <= 0) and any same-cycle pop or push discarded;
  - fetch_pc <= {redirect_pc_i[31:2], 2'b00};
  - no request issued that cycle.
REQ-025 Redirect state transitions:
  - redirect in WAIT with icache_rvalid_i=0 -> KILL;
  - redirect in WAIT with icache_rvalid_i=1 -> FETCH (response dropped);
  - redirect in FETCH -> FETCH;
  - redirect in KILL -> KILL.
REQ-026 In KILL, SHALL discard the next icache_rvalid_i=1 response without pushing it, then go to FETCH.
REQ-027 On a second redirect while in KILL, SHALL keep the latest target and stay in KILL until the response arrives.
REQ-028 Instruction latency SHALL be: request cycle T, response cycle T+N (N>=1), inst_valid_o=1 from cycle T+N+1.

Reset
REQ-029 While rst_i=1 at a clock edge, SHALL set:
  - state = FETCH, fetch_pc = BOOT_PC, count = 0;
  - icache_req_o = 0, inst_valid_o = 0, inst_o = 0, pc_o = 0.
REQ-030 Reset SHALL override redirect and any outstanding request; a response arriving after reset is released SHALL be ignored (state is FETCH).
REQ-031 The first request SHALL occur in the first cycle after rst_i deasserts, with icache_addr_o=BOOT_PC.

Verification
REQ-032 Reset release, cache latency 1, dec_ready_i=1 -> requests at addresses 0, 4, 8 every 2 cycles; pc_o/inst_o follow in order with no gaps beyond the required latency.
REQ-033 dec_ready_i=0 for 10 cycles -> exactly 2 requests issued, FIFO full, head stays pc_o=0; after dec_ready_i=1 -> pc 0 then pc 4 presented, fetching resumes at 8.
REQ-034 redirect_i=1 with redirect_pc_i=32'h0000_0103 while in WAIT (latency 3) -> stale response dropped, inst_valid_o=0, next request to 32'h0000_0100.
REQ-035 Redirect in the same cycle as icache_rvalid_i in WAIT -> response not pushed; request to the target issued on the next cycle.
REQ-036 BOOT_PC=32'hFFFF_FFFC -> second request to 32'h0000_0000.
REQ-037 rst_i=1 mid-WAIT, then a late icache_rvalid_i -> nothing pushed, first request to BOOT_PC.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding I-cache request, a 2-entry
// {pc, inst} buffer toward decode, and redirect handling that flushes in-flight work.
module fetch_ctrl #(
    parameter logic [31:0] BOOT_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        icache_req_o,
    output logic [31:0] icache_addr_o,
    input  logic        icache_rvalid_i,
    input  logic [31:0] icache_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        dec_ready_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o
);
    typedef enum logic [1:0] {FETCH = 2'd0, WAIT = 2'd1, KILL = 2'd2} state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] req_pc;
    logic [31:0] pc_q   [2];
    logic [31:0] inst_q [2];
    logic [1:0]  count;
    logic        head_valid;
    logic        issue;
    logic        push;
    logic        pop;

    // Handshakes: a request is a one-cycle pulse with no back-pressure; the
    // response is the single icache_rvalid_i pulse that follows it. Decode
    // takes the head on inst_valid_o && dec_ready_i. Redirect cancels all.
    assign head_valid = (count != 2'd0);
    assign issue      = !rst_i && !redirect_i && (state == FETCH) && (count < 2'd2);
    assign push       = (state == WAIT) && icache_rvalid_i && !redirect_i;
    assign pop        = head_valid && dec_ready_i && !redirect_i;

    assign icache_req_o  = issue;
    assign icache_addr_o = fetch_pc;
    assign inst_valid_o  = head_valid;
    assign inst_o        = head_valid ? inst_q[0] : 32'd0;
    assign pc_o          = head_valid ? pc_q[0]   : 32'd0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= FETCH;
            fetch_pc  <= BOOT_PC;
            req_pc    <= BOOT_PC;
            count     <= 2'd0;
            pc_q[0]   <= 32'd0;
            pc_q[1]   <= 32'd0;
            inst_q[0] <= 32'd0;
            inst_q[1] <= 32'd0;
        end else if (redirect_i) begin
            count    <= 2'd0;
            fetch_pc <= redirect_pc_i & 32'hFFFF_FFFC;
            // A response landing in the redirect cycle is the outstanding one,
            // so it is consumed here rather than waited for in KILL.
            case (state)
                WAIT:    state <= icache_rvalid_i ? FETCH : KILL;
                KILL:    state <= icache_rvalid_i ? FETCH : KILL;
                default: state <= FETCH;
            endcase
        end else begin
            case (state)
                FETCH: begin
                    if (issue) begin
                        req_pc   <= fetch_pc;
                        fetch_pc <= fetch_pc + 32'd4;
                        state    <= WAIT;
                    end
                end
                WAIT:    if (icache_rvalid_i) state <= FETCH;
                KILL:    if (icache_rvalid_i) state <= FETCH;
                default: state <= FETCH;
            endcase

            if (push && pop) begin
                if (count == 2'd1) begin
                    pc_q[0]   <= req_pc;
                    inst_q[0] <= icache_rdata_i;
                end else begin
                    pc_q[0]   <= pc_q[1];
                    inst_q[0] <= inst_q[1];
                    pc_q[1]   <= req_pc;
                    inst_q[1] <= icache_rdata_i;
                end
            end else if (push) begin
                pc_q[count[0]]   <= req_pc;
                inst_q[count[0]] <= icache_rdata_i;
                count            <= count + 2'd1;
            end else if (pop) begin
                pc_q[0]   <= pc_q[1];
                inst_q[0] <= inst_q[1];
                pc_q[1]   <= 32'd0;
                inst_q[1] <= 32'd0;
                count     <= count - 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: I-cache responder, queue-based reference model checked
// every cycle, and directed scenario tasks with their own inline checks.
`timescale 1ns/1ps
module tb_fetch_ctrl;
    logic        clk = 0;
    logic        rst_i = 1;
    logic        icache_req_o;
    logic [31:0] icache_addr_o;
    logic        icache_rvalid_i = 0;
    logic [31:0] icache_rdata_i = 0;
    logic        redirect_i = 0;
    logic [31:0] redirect_pc_i = 0;
    logic        dec_ready_i = 0;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_rvalid = 0;
    logic        w_valid;
    logic [31:0] w_inst;
    logic [31:0] w_pc;

    int checks = 0;
    int errors = 0;
    int cyc_no = 0;

    // responder state
    int  cache_timer = 0;
    int  lat = 1;
    bit  lat_rand = 0;

    // reference model
    logic [63:0] exp_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_issued;
    bit          m_out;
    bit          m_drop;
    bit          m_on = 0;

    always #10 clk = ~clk;

    fetch_ctrl #(.BOOT_PC(32'h0000_0000)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .icache_req_o(icache_req_o), .icache_addr_o(icache_addr_o),
        .icache_rvalid_i(icache_rvalid_i), .icache_rdata_i(icache_rdata_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .dec_ready_i(dec_ready_i),
        .inst_valid_o(inst_valid_o), .inst_o(inst_o), .pc_o(pc_o)
    );

    fetch_ctrl #(.BOOT_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk_i(clk), .rst_i(rst_i),
        .icache_req_o(w_req), .icache_addr_o(w_addr),
        .icache_rvalid_i(w_rvalid), .icache_rdata_i(32'hCAFE_0001),
        .redirect_i(1'b0), .redirect_pc_i(32'd0),
        .dec_ready_i(1'b1),
        .inst_valid_o(w_valid), .inst_o(w_inst), .pc_o(w_pc)
    );

    // I-cache responder: response lat cycles after the request cycle
    always @(negedge clk) begin
        #1;
        icache_rvalid_i = 0;
        if (cache_timer > 0) begin
            cache_timer = cache_timer - 1;
            if (cache_timer == 0) begin
                icache_rvalid_i = 1;
                icache_rdata_i  = $urandom;
            end
        end
        #3;
        if (icache_req_o === 1'b1)
            cache_timer = lat_rand ? $urandom_range(1, 4) : lat;
    end

    // scoreboard: compare every cycle, then advance the model across the edge
    always @(negedge clk) begin
        logic        e_req;
        logic        e_valid;
        logic [63:0] e_head;
        #5;
        cyc_no++;
        if (m_on) begin
            e_req   = !rst_i && !redirect_i && !m_out && (exp_q.size() < 2);
            e_valid = (exp_q.size() != 0);
            e_head  = e_valid ? exp_q[0] : 64'd0;
            checks++;
            if (icache_req_o !== e_req) begin
                errors++;
                $display("FAIL sb_req cycle %0d got %0b exp %0b", cyc_no, icache_req_o, e_req);
            end
            checks++;
            if (icache_addr_o !== m_pc) begin
                errors++;
                $display("FAIL sb_addr cycle %0d got %h exp %h", cyc_no, icache_addr_o, m_pc);
            end
            checks++;
            if (inst_valid_o !== e_valid || pc_o !== e_head[63:32] || inst_o !== e_head[31:0]) begin
                errors++;
                $display("FAIL sb_head cycle %0d got v=%0b pc=%h inst=%h exp v=%0b pc=%h inst=%h",
                         cyc_no, inst_valid_o, pc_o, inst_o, e_valid, e_head[63:32], e_head[31:0]);
            end
        end
        if (rst_i) begin
            exp_q.delete();
            m_pc = 32'h0000_0000; m_out = 0; m_drop = 0; m_on = 1;
        end else if (m_on && redirect_i) begin
            exp_q.delete();
            m_pc = {redirect_pc_i[31:2], 2'b00};
            if (m_out) begin
                if (icache_rvalid_i) begin m_out = 0; m_drop = 0; end
                else m_drop = 1;
            end
        end else if (m_on) begin
            e_req = !m_out && (exp_q.size() < 2);
            if (exp_q.size() != 0 && dec_ready_i) void'(exp_q.pop_front());
            if (e_req) begin
                m_out = 1; m_issued = m_pc; m_pc = m_pc + 32'd4;
            end else if (m_out && icache_rvalid_i) begin
                if (m_drop) m_drop = 0;
                else exp_q.push_back({m_issued, icache_rdata_i});
                m_out = 0;
            end
        end
    end

    task automatic cyc(input logic r, input logic red, input logic [31:0] rpc, input logic dr);
        @(negedge clk);
        rst_i = r; redirect_i = red; redirect_pc_i = rpc; dec_ready_i = dr;
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 1);
        cache_timer = 0;
        lat_rand = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #6;
        checks++;
        if (icache_req_o !== 0 || inst_valid_o !== 0 || inst_o !== 0 || pc_o !== 0) begin
            errors++;
            $display("FAIL reset_outputs got req=%0b v=%0b inst=%h pc=%h exp all 0",
                     icache_req_o, inst_valid_o, inst_o, pc_o);
        end
        cyc(0, 0, 0, 1);
        #6;
        checks++;
        if (icache_req_o !== 1 || icache_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL first_req got req=%0b addr=%h exp 1 00000000", icache_req_o, icache_addr_o);
        end
    endtask

    task automatic test_stream();
        lat = 1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 0, 1);
            #6;
            checks++;
            if (icache_req_o !== (i % 2 == 0) || (i % 2 == 0 && icache_addr_o !== 32'(2 * i))) begin
                errors++;
                $display("FAIL stream_req i=%0d got req=%0b addr=%h exp req=%0b addr=%h",
                         i, icache_req_o, icache_addr_o, (i % 2 == 0), 32'(2 * i));
            end
            if (i >= 2) begin
                checks++;
                if (inst_valid_o !== (i % 2 == 0) || (i % 2 == 0 && pc_o !== 32'(2 * (i - 2)))) begin
                    errors++;
                    $display("FAIL stream_head i=%0d got v=%0b pc=%h", i, inst_valid_o, pc_o);
                end
            end
        end
    endtask

    task automatic test_stall();
        int reqs = 0;
        lat = 1;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 0);
            #6;
            if (icache_req_o === 1'b1) reqs++;
        end
        checks++;
        if (reqs != 2 || inst_valid_o !== 1 || pc_o !== 32'h0) begin
            errors++;
            $display("FAIL stall_full got reqs=%0d v=%0b pc=%h exp 2 1 00000000", reqs, inst_valid_o, pc_o);
        end
        cyc(0, 0, 0, 1);
        #6;
        checks++;
        if (pc_o !== 32'h0 || icache_req_o !== 0) begin
            errors++;
            $display("FAIL stall_pop0 got pc=%h req=%0b exp 00000000 0", pc_o, icache_req_o);
        end
        cyc(0, 0, 0, 1);
        #6;
        checks++;
        if (pc_o !== 32'h4 || icache_req_o !== 1 || icache_addr_o !== 32'h8) begin
            errors++;
            $display("FAIL stall_resume got pc=%h req=%0b addr=%h exp 00000004 1 00000008",
                     pc_o, icache_req_o, icache_addr_o);
        end
        repeat (6) cyc(0, 0, 0, 1);
    endtask

    task automatic test_redirect_wait();
        lat = 3;
        do_reset();
        cyc(0, 0, 0, 1);
        cyc(0, 1, 32'h0000_0103, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        #6;
        checks++;
        if (icache_rvalid_i !== 1 || icache_req_o !== 0 || inst_valid_o !== 0) begin
            errors++;
            $display("FAIL redir_kill got rvalid=%0b req=%0b v=%0b exp 1 0 0", icache_rvalid_i, icache_req_o, inst_valid_o);
        end
        cyc(0, 0, 0, 1);
        #6;
        checks++;
        if (icache_req_o !== 1 || icache_addr_o !== 32'h100 || inst_valid_o !== 0) begin
            errors++;
            $display("FAIL redir_target got req=%0b addr=%h v=%0b exp 1 00000100 0",
                     icache_req_o, icache_addr_o, inst_valid_o);
        end
        repeat (6) cyc(0, 0, 0, 1);
    endtask

    task automatic test_redirect_rvalid();
        lat = 2;
        do_reset();
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 32'h0000_0200, 1);
        #6;
        checks++;
        if (icache_rvalid_i !== 1) begin
            errors++;
            $display("FAIL redir_rv_align got rvalid=%0b exp 1", icache_rvalid_i);
        end
        cyc(0, 0, 0, 1);
        #6;
        checks++;
        if (icache_req_o !== 1 || icache_addr_o !== 32'h200 || inst_valid_o !== 0) begin
            errors++;
            $display("FAIL redir_rv_next got req=%0b addr=%h v=%0b exp 1 00000200 0",
                     icache_req_o, icache_addr_o, inst_valid_o);
        end
        repeat (6) cyc(0, 0, 0, 1);
    endtask

    task automatic test_wrap();
        lat = 1;
        do_reset();
        cyc(0, 0, 0, 1);
        #6;
        checks++;
        if (w_req !== 1 || w_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_first got req=%0b addr=%h exp 1 fffffffc", w_req, w_addr);
        end
        cyc(0, 0, 0, 1);
        w_rvalid = 1;
        cyc(0, 0, 0, 1);
        w_rvalid = 0;
        #6;
        checks++;
        if (w_req !== 1 || w_addr !== 32'h0 || w_valid !== 1 || w_pc !== 32'hFFFF_FFFC || w_inst !== 32'hCAFE_0001) begin
            errors++;
            $display("FAIL wrap_second got req=%0b addr=%h v=%0b pc=%h inst=%h exp 1 00000000 1 fffffffc cafe0001",
                     w_req, w_addr, w_valid, w_pc, w_inst);
        end
    endtask

    task automatic test_reset_mid_wait();
        lat = 3;
        do_reset();
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 1);
        cyc(0, 0, 0, 1);
        #6;
        checks++;
        if (icache_rvalid_i !== 1 || icache_req_o !== 1 || icache_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL rst_wait_req got rvalid=%0b req=%0b addr=%h exp 1 1 00000000",
                     icache_rvalid_i, icache_req_o, icache_addr_o);
        end
        cyc(0, 0, 0, 1);
        #6;
        checks++;
        if (inst_valid_o !== 0) begin
            errors++;
            $display("FAIL rst_wait_drop got v=%0b exp 0", inst_valid_o);
        end
        repeat (6) cyc(0, 0, 0, 1);
    endtask

    task automatic test_random();
        do_reset();
        lat_rand = 1;
        for (int i = 0; i < 2000; i++)
            cyc(0, ($urandom_range(0, 15) == 0), $urandom, ($urandom_range(0, 3) != 0));
        cyc(0, 0, 0, 1);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_rvalid();
        test_wrap();
        test_reset_mid_wait();
        test_random();
        @(negedge clk);
        #8;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
